rgb_fader: RTL and testbench
============================

RGB_FADER -- requirements
Module: rgb_fader

Interface
REQ-001 Parameter PWM_BITS, default 8: width of brightness level, duty and PWM counter.
REQ-002 Parameter STEP, default 8: brightness increment/decrement per tick edge; legal range 1..2^PWM_BITS-1.
REQ-003 i_clk  input  1  system clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_en  input  1  run enable; low freezes sequencing and blanks LEDs.
REQ-006 i_tick  input  1  slow square wave from the free-running timer's MSB; each rising edge is one fade step.
REQ-007 o_red, o_green, o_blue  output  1 each  registered PWM LED drives, active-high.
REQ-008 o_phase  output  2  current colour: 0 red, 1 green, 2 blue; 3 never produced.

Function
REQ-009 The block SHALL keep a tick_q register loading i_tick every cycle, including during reset; edge = i_tick & ~tick_q.
REQ-010 The block SHALL hold MAX = 2^PWM_BITS-1, state {colour, dir (UP/DOWN), level[PWM_BITS-1:0]}.
REQ-011 On edge with i_en=1, dir=UP: if level+STEP >= MAX (computed at PWM_BITS+1 width), level<=MAX and dir<=DOWN; else level<=level+STEP.
REQ-012 On edge with i_en=1, dir=DOWN: if level <= STEP, level<=0, dir<=UP, colour advances red->green->blue->red; else level<=level-STEP.
REQ-013 Without an edge, or with i_en=0, colour, dir and level SHALL hold; edges during i_en=0 are discarded, not queued.
REQ-014 A free-running PWM_BITS counter pwm_cnt SHALL increment every cycle regardless of i_en, wrapping MAX->0.
REQ-015 duty SHALL equal level (see REQ-022 for macro variant); the active colour output SHALL register (pwm_cnt < duty); the other two outputs register 0.
REQ-016 Latency: a level/colour update is visible on outputs from the second clock edge after the tick edge is sampled (one cycle state update, one cycle output register).
REQ-017 Boundaries: duty 0 -> output constantly 0; duty MAX -> high MAX of every 2^PWM_BITS cycles; only one output high at any cycle.
REQ-018 i_en=0 SHALL force all three outputs to 0 on the next clock edge; on i_en=1 sequencing resumes from frozen state.
REQ-019 o_phase SHALL reflect colour combinationally from the state register.

Reset
REQ-020 While i_rst=1 at a clock edge: colour<=red, dir<=UP, level<=0, pwm_cnt<=0, o_red/o_green/o_blue<=0; o_phase reads 0.
REQ-021 Reset mid-fade SHALL discard all progress; an i_tick already high at reset release SHALL NOT produce an edge (per REQ-009).

Configuration
REQ-022 Macro RGB_FADER_GAMMA_EN defined: duty = (level*level) >> PWM_BITS (full 2*PWM_BITS product, truncated), giving perceptual fade; undefined: duty = level, no multiplier synthesised.

Verification
REQ-023 PWM_BITS=8, STEP=64, i_en=1, 8 tick edges -> level sequence 64,128,192,255,191,127,63,0; after 8th edge o_phase=1, dir=UP.
REQ-024 24 edges at same parameters -> o_phase cycles 0->1->2->0; o_green/o_blue never high during phase 0, etc.
REQ-025 Level held at 128, macro undefined -> active output high exactly 128 of 256 cycles; macro defined -> 64 of 256; level 255 defined -> 254 of 256.
REQ-026 i_en dropped at level 128 for 4 tick edges then raised -> outputs 0 one cycle after drop, level still 128 after resume, next edge gives 192.
REQ-027 i_rst pulsed at level 192 phase 2 with i_tick held high -> all outputs 0, o_phase=0, level 0; no step until i_tick falls and rises again.
REQ-028 Level 0 and level 255 held for 512 cycles each -> output never high / low exactly 1 cycle per 256-cycle period.

Source files
------------

// File: rtl/rgb_fader.sv
// rgb_fader: cycles a single RGB LED through red, green and blue, fading each
// colour up and then down in STEP increments. One fade step is taken on
// every rising edge of i_tick while i_en is high. The active colour is
// driven with a registered PWM; the other two outputs are held low.
//
// Optional feature macro: RGB_FADER_GAMMA_EN
//   defined   : duty = (level*level) >> PWM_BITS (perceptual fade)
//   undefined : duty = level (no multiplier)
module rgb_fader #(
  parameter int PWM_BITS = 8,
  parameter int STEP     = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_tick,
  output logic       o_red,
  output logic       o_green,
  output logic       o_blue,
  output logic [1:0] o_phase
);

  localparam logic [PWM_BITS-1:0] MAX    = '1;
  localparam logic [PWM_BITS:0]   MAX_W  = {1'b0, MAX};
  localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(STEP);

  typedef enum logic [1:0] {
    COL_RED   = 2'd0,
    COL_GREEN = 2'd1,
    COL_BLUE  = 2'd2
  } colour_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic                r_tick_q;
  colour_t             r_colour;
  colour_t             w_colour_next;
  dir_t                r_dir;
  dir_t                w_dir_next;
  logic [PWM_BITS-1:0] r_level;
  logic [PWM_BITS-1:0] w_level_next;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] w_duty;
  logic [PWM_BITS:0]   w_level_ext;
  logic [PWM_BITS:0]   w_sum;
  logic                w_edge;
  logic                w_pwm_on;
  logic [2:0]          r_leds;

  // Tick history: loaded every cycle, reset included, so a tick that is
  // already high when reset releases never looks like a fresh edge.
  always_ff @(posedge i_clk) begin
    r_tick_q <= i_tick;
  end

  assign w_edge      = i_tick & ~r_tick_q;
  assign w_level_ext = {1'b0, r_level};
  assign w_sum       = w_level_ext + STEP_W;

  // Fade state register: colour, direction and brightness level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_colour <= COL_RED;
      r_dir    <= DIR_UP;
      r_level  <= '0;
    end else begin
      r_colour <= w_colour_next;
      r_dir    <= w_dir_next;
      r_level  <= w_level_next;
    end
  end

  // Next-state: one step per accepted tick edge; saturate at MAX going up,
  // clamp at 0 going down and then hand over to the next colour.
  always_comb begin
    w_colour_next = r_colour;
    w_dir_next    = r_dir;
    w_level_next  = r_level;
    if (w_edge && i_en) begin
      if (r_dir == DIR_UP) begin
        if (w_sum >= MAX_W) begin
          w_level_next = MAX;
          w_dir_next   = DIR_DOWN;
        end else begin
          w_level_next = w_sum[PWM_BITS-1:0];
        end
      end else begin
        if (w_level_ext <= STEP_W) begin
          w_level_next = '0;
          w_dir_next   = DIR_UP;
          case (r_colour)
            COL_RED:   w_colour_next = COL_GREEN;
            COL_GREEN: w_colour_next = COL_BLUE;
            default:   w_colour_next = COL_RED;
          endcase
        end else begin
          w_level_next = r_level - STEP_W[PWM_BITS-1:0];
        end
      end
    end
  end

  // Free-running PWM counter; keeps counting even while disabled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end
  end

`ifdef RGB_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] w_level_sq;
  assign w_level_sq = {{PWM_BITS{1'b0}}, r_level} * {{PWM_BITS{1'b0}}, r_level};
  assign w_duty     = w_level_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign w_duty = r_level;
`endif

  // Duty MAX gives MAX high cycles per period, duty 0 gives none.
  assign w_pwm_on = (r_pwm_cnt < w_duty);

  // One registered drive per colour; only the active colour can be high.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_led
      always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
          r_leds[gi] <= 1'b0;
        end else begin
          r_leds[gi] <= w_pwm_on && (r_colour == colour_t'(gi));
        end
      end
    end
  endgenerate

  assign o_red   = r_leds[0];
  assign o_green = r_leds[1];
  assign o_blue  = r_leds[2];
  assign o_phase = r_colour;

endmodule

// File: tb/tb_rgb_fader.sv
// Testbench for rgb_fader at PWM_BITS=8, STEP=64. A sequence-level model
// (fade table + accepted-edge count) predicts every output each cycle;
// directed scenarios add literal duty counts and phase checks.
module tb_rgb_fader;

  localparam int PB   = 8;
  localparam int STP  = 64;
  localparam int MAXV = (1 << PB) - 1;
  localparam int PER  = 1 << PB;

`ifdef RGB_FADER_GAMMA_EN
  localparam int HI_128 = 64;
  localparam int HI_192 = 144;
  localparam int HI_255 = 254;
  localparam int HI_64  = 16;
`else
  localparam int HI_128 = 128;
  localparam int HI_192 = 192;
  localparam int HI_255 = 255;
  localparam int HI_64  = 64;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       tick = 1'b0;
  logic       o_red, o_green, o_blue;
  logic [1:0] o_phase;

  int n_vec = 0;
  int n_err = 0;

  rgb_fader #(.PWM_BITS(PB), .STEP(STP)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (en),
    .i_tick (tick),
    .o_red  (o_red),
    .o_green(o_green),
    .o_blue (o_blue),
    .o_phase(o_phase)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  int lvl_tab [0:1023];
  int period_len = 0;
  int m_edges = 0;
  int m_cnt = 0;
  bit m_tick_prev = 1'b0;
  bit m_valid = 1'b0;
  bit exp_r = 1'b0, exp_g = 1'b0, exp_b = 1'b0;

  function automatic int duty_of(input int lvl);
`ifdef RGB_FADER_GAMMA_EN
    return (lvl * lvl) >> PB;
`else
    return lvl;
`endif
  endfunction

  // Levels seen after each accepted edge within one colour's fade.
  initial begin
    int l;
    bit up;
    int j;
    l = 0; up = 1'b1; j = 1;
    lvl_tab[0] = 0;
    while (j < 1024) begin
      if (up) begin
        if (l + STP >= MAXV) begin l = MAXV; up = 1'b0; end
        else l = l + STP;
      end else begin
        if (l <= STP) break;
        l = l - STP;
      end
      lvl_tab[j] = l;
      j++;
    end
    period_len = j;
  end

  always @(posedge clk) begin
    int lvl, col;
    bit on;
    if (rst) begin
      exp_r = 1'b0; exp_g = 1'b0; exp_b = 1'b0;
      m_cnt = 0; m_edges = 0;
    end else begin
      lvl = lvl_tab[m_edges % period_len];
      col = (m_edges / period_len) % 3;
      on  = en && (m_cnt < duty_of(lvl));
      exp_r = on && (col == 0);
      exp_g = on && (col == 1);
      exp_b = on && (col == 2);
      m_cnt = (m_cnt + 1) % PER;
      if (en && tick && !m_tick_prev) m_edges++;
    end
    m_tick_prev = tick;
    m_valid = 1'b1;
  end

  // Cycle compare against the model.
  always @(negedge clk) begin
    int exp_ph;
    if (m_valid) begin
      exp_ph = (m_edges / period_len) % 3;
      n_vec++;
      if ({o_red, o_green, o_blue} !== {exp_r, exp_g, exp_b} || int'(o_phase) != exp_ph) begin
        n_err++;
        $display("FAIL cycle_check t=%0t act rgb=%b%b%b phase=%0d exp rgb=%b%b%b phase=%0d",
                 $time, o_red, o_green, o_blue, o_phase, exp_r, exp_g, exp_b, exp_ph);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic tick_edge();
    tick = 1'b1; cyc(3);
    tick = 1'b0; cyc(3);
  endtask

  task automatic edges(input int n);
    for (int k = 0; k < n; k++) tick_edge();
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // which: 0 red, 1 green, 2 blue, 3 any output high
  task automatic count_high(input int which, input int ncyc, output int c);
    c = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      case (which)
        0: c += int'(o_red);
        1: c += int'(o_green);
        2: c += int'(o_blue);
        default: c += int'(o_red | o_green | o_blue);
      endcase
    end
    @(posedge clk); #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int pin [8];
    pin = '{0, 64, 128, 192, 255, 191, 127, 63};

    cyc(3);
    check("model_period", period_len, 8);
    for (int k = 1; k < 8; k++) check($sformatf("model_lvl%0d", k), lvl_tab[k], pin[k]);

    check("reset_phase", int'(o_phase), 0);
    count_high(3, 8, c);
    check("reset_leds", c, 0);
    rst = 1'b0; en = 1'b1;

    edges(2);
    count_high(0, PER, c);
    check("lvl128_red", c, HI_128);
    count_high(1, PER, c);
    check("lvl128_green", c, 0);

    en = 1'b0; cyc(1);
    count_high(3, 1, c);
    check("en_drop_blank", c, 0);
    edges(4);
    en = 1'b1; cyc(2);
    count_high(0, PER, c);
    check("resume_lvl128", c, HI_128);
    edges(1);
    count_high(0, PER, c);
    check("resume_lvl192", c, HI_192);

    edges(1);
    count_high(0, 2 * PER, c);
    check("lvl255_red_512", c, 2 * HI_255);

    edges(4);
    check("phase_after8", int'(o_phase), 1);
    count_high(3, 2 * PER, c);
    check("lvl0_any_512", c, 0);

    edges(11);
    check("phase_after19", int'(o_phase), 2);
    count_high(2, PER, c);
    check("lvl192_blue", c, HI_192);

    tick = 1'b1; cyc(2);
    rst = 1'b1; cyc(2);
    rst = 1'b0; cyc(5);
    check("rst_phase", int'(o_phase), 0);
    count_high(3, PER, c);
    check("rst_no_step", c, 0);
    tick = 1'b0; cyc(3);
    tick = 1'b1; cyc(3);
    tick = 1'b0; cyc(3);
    count_high(0, PER, c);
    check("post_rst_lvl64", c, HI_64);

    edges(26);
    check("phase_after27", int'(o_phase), 0);
    cyc(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
